sha256_msg_schedule: RTL
========================

SHA256_MSG_SCHEDULE -- requirements
Module: sha256_msg_schedule

Interface
REQ-001 SHALL have parameter WORD_W, default 32, message/schedule word width.
REQ-002 SHALL have parameter ROUNDS, default 64, schedule words produced per block.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse, begins a new 512-bit block.
REQ-006 SHALL have port word_valid_i  input  1  message word on word_i is valid.
REQ-007 SHALL have port word_i  input  WORD_W  message word M_t, big-endian order, t=0..15.
REQ-008 SHALL have port word_ready_o  output  1  high only while in LOAD; word accepted when word_valid_i & word_ready_o.
REQ-009 SHALL have port hold_i  input  1  downstream stall; freezes EXPAND progress and outputs.
REQ-010 SHALL have port w_valid_o  output  1  w_o/round_o carry schedule word W_t this cycle.
REQ-011 SHALL have port w_o  output  WORD_W  schedule word W_t.
REQ-012 SHALL have port round_o  output  6  index t of w_o.
REQ-013 SHALL have port busy_o  output  1  high in LOAD or EXPAND.
REQ-014 SHALL have port done_o  output  1  one-cycle pulse after W_63 is presented.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, EXPAND, DONE.
REQ-016 IDLE: start -> LOAD, round counter cleared to 0; start in any other state ignored.
REQ-017 LOAD: each accepted word M_t is written to a 16-entry shift window and presented as w_o=M_t, round_o=t, w_valid_o=1 on the next cycle; counter increments per accepted word.
REQ-018 LOAD: cycles without word_valid_i SHALL stall (no counter change, w_valid_o=0); hold_i is ignored in LOAD.
REQ-019 LOAD -> EXPAND after acceptance of word t=15.
REQ-020 EXPAND: each cycle with hold_i=0 computes W_t = sigma1(W_t-2) + W_t-7 + sigma0(W_t-15) + W_t-16 mod 2^32, shifts it into the window, presents it registered next cycle, t=16..63.
REQ-021 sigma0(x)=ROTR7^ROTR18^SHR3; sigma1(x)=ROTR17^ROTR19^SHR10; carries beyond bit 31 discarded.
REQ-022 EXPAND with hold_i=1: window, counter, w_o, round_o, w_valid_o all hold their current values.
REQ-023 After W_63 computed -> DONE; DONE asserts done_o for exactly one cycle, w_valid_o=0, then -> IDLE.
REQ-024 Exactly ROUNDS words with w_valid_o=1 SHALL be emitted per block, round_o strictly increasing 0..63, no duplicates except held cycles.
REQ-025 Minimum block latency: start to done_o = 1 + 16 (no gaps) + 48 + 1 cycles = 66 cycles.
REQ-026 word_valid_i outside LOAD SHALL be ignored; start coincident with done_o SHALL be ignored.

Reset
REQ-027 RST=1 at a clock edge SHALL force IDLE, counter=0, window cleared, w_o=0, round_o=0, w_valid_o=0, word_ready_o=0, busy_o=0, done_o=0.
REQ-028 RST mid-block SHALL abandon the block; no done_o is produced for it.
REQ-029 RST SHALL take priority over start, word_valid_i and hold_i in the same cycle.

Structure
REQ-030 Shared package sha256_pkg SHALL hold WORD_W/ROUNDS constants, FSM state typedef, and sigma0/sigma1 functions.
REQ-031 One sub-module sha256_sigma (combinational, selects sigma0/sigma1 by parameter) SHALL be instantiated twice.
REQ-032 Window SHALL be a 16x32 shift register; no RAM inferred.

Verification
REQ-033 "abc" block (M0=0x61626380, M1..M14=0, M15=0x00000018), no gaps, hold_i=0 -> W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W63=0x12B1EDEB; done_o at cycle 66 after start.
REQ-034 Same block with word_valid_i low every other cycle -> identical W sequence, done_o delayed by 15 cycles.
REQ-035 hold_i high 5 cycles at t=30 -> w_o/round_o frozen at W30/30 for 5 extra cycles, sequence otherwise unchanged.
REQ-036 RST asserted at t=40 -> all outputs 0 next cycle, no done_o; fresh start then produces full correct sequence.
REQ-037 start pulsed during EXPAND and word_valid_i driven during EXPAND -> no effect on W sequence or counter.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 schedule constants, FSM state type and small-sigma helpers.
// Pure declarations: no logic, no latency.
// No flow control here; users decide when to apply the functions.
package sha256_pkg;

  localparam int SHA_WORD_W = 32;
  localparam int SHA_ROUNDS = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2,
    DONE   = 2'd3
  } state_t;

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [SHA_WORD_W-1:0] sigma0(input logic [SHA_WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [SHA_WORD_W-1:0] sigma1(input logic [SHA_WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// Message-word input and schedule-word output bundle of the message scheduler.
// Wires only, no latency.
// Input side is valid/ready; output side is stalled by hold_i.
interface sha256_msg_schedule_if import sha256_pkg::*; #(
  parameter int WORD_W = SHA_WORD_W
) ();

  logic              word_valid_i;
  logic [WORD_W-1:0] word_i;
  logic              word_ready_o;
  logic              hold_i;
  logic              w_valid_o;
  logic [WORD_W-1:0] w_o;
  logic [5:0]        round_o;

  // scheduler side
  modport slave (
    input  word_valid_i, word_i, hold_i,
    output word_ready_o, w_valid_o, w_o, round_o
  );

  // message source / schedule consumer side
  modport master (
    output word_valid_i, word_i, hold_i,
    input  word_ready_o, w_valid_o, w_o, round_o
  );

endinterface

// File: rtl/sha256_sigma.sv
// Combinational SHA-256 small sigma; UPPER=0 selects sigma0, UPPER=1 sigma1.
// Zero latency.
// No flow control.
module sha256_sigma import sha256_pkg::*; #(
  parameter int WORD_W = SHA_WORD_W,
  parameter bit UPPER  = 1'b0
) (
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y
);

  assign y = WORD_W'(UPPER ? sigma1(SHA_WORD_W'(x)) : sigma0(SHA_WORD_W'(x)));

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads M0..M15, expands W16..W63, presents W_t registered.
// Each accepted/computed word appears one cycle later; start to done_o is 66 cycles minimum.
// Input stalls on word_valid_i gaps; hold_i freezes expansion and outputs in EXPAND.
module sha256_msg_schedule import sha256_pkg::*; #(
  parameter int WORD_W = SHA_WORD_W,
  parameter int ROUNDS = SHA_ROUNDS
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  sha256_msg_schedule_if.slave  sched,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [5:0] LAST_LOAD  = 6'd15;
  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [5:0]              cnt;
  // win[15] is the newest word W_t-1, win[0] the oldest W_t-16
  logic [15:0][WORD_W-1:0] win;
  logic [WORD_W-1:0]       s0;
  logic [WORD_W-1:0]       s1;
  logic [WORD_W-1:0]       w_new;
  logic                    accept;
  logic                    advance;

  sha256_sigma #(.WORD_W(WORD_W), .UPPER(1'b0)) u_sigma0 (.x(win[1]),  .y(s0));
  sha256_sigma #(.WORD_W(WORD_W), .UPPER(1'b1)) u_sigma1 (.x(win[14]), .y(s1));

  assign w_new   = s1 + win[9] + s0 + win[0];
  assign accept  = (state == LOAD) && sched.word_valid_i;
  assign advance = (state == EXPAND) && !sched.hold_i;

  assign sched.word_ready_o = (state == LOAD);
  assign busy_o             = (state == LOAD) || (state == EXPAND);

  // state register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state decode; start is only honoured from a quiet IDLE (not on the done_o cycle)
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !done_o)                 state_nxt = LOAD;
      LOAD:    if (accept && (cnt == LAST_LOAD))     state_nxt = EXPAND;
      EXPAND:  if (advance && (cnt == LAST_ROUND))   state_nxt = DONE;
      DONE:                                          state_nxt = IDLE;
      default:                                       state_nxt = IDLE;
    endcase
  end

  // round counter and 16-word shift window
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
      win <= '0;
    end else if ((state == IDLE) && (state_nxt == LOAD)) begin
      cnt <= '0;
    end else if (accept) begin
      win <= {sched.word_i, win[15:1]};
      cnt <= cnt + 6'd1;
    end else if (advance) begin
      win <= {w_new, win[15:1]};
      cnt <= cnt + 6'd1;
    end
  end

  // registered outputs; a held EXPAND cycle keeps every output as it is
  always_ff @(posedge CLK) begin
    if (RST) begin
      sched.w_valid_o <= 1'b0;
      sched.w_o       <= '0;
      sched.round_o   <= '0;
      done_o          <= 1'b0;
    end else begin
      done_o <= (state == DONE);
      if (accept) begin
        sched.w_valid_o <= 1'b1;
        sched.w_o       <= sched.word_i;
        sched.round_o   <= cnt;
      end else if (advance) begin
        sched.w_valid_o <= 1'b1;
        sched.w_o       <= w_new;
        sched.round_o   <= cnt;
      end else if (state != EXPAND) begin
        sched.w_valid_o <= 1'b0;
      end
    end
  end

endmodule
